pu_msp430_dbg_mem_ctl: RTL and testbench



---
 rtl/pu_msp430_dbg_mem_ctl.sv | 170 +++++++++++++++++
 tb/tb_pu_msp430_dbg_mem_ctl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_msp430_dbg_mem_ctl.sv
// Debug memory-access controller: owns MEM_CTL/ADDR/DATA/CNT and runs single or
// burst 8/16-bit accesses on the CPU memory bus for the serial debug front-end.
module pu_msp430_dbg_mem_ctl #(
    parameter logic [5:0] MEM_CTL  = 6'h04,
    parameter logic [5:0] MEM_ADDR = 6'h05,
    parameter logic [5:0] MEM_DATA = 6'h06,
    parameter logic [5:0] MEM_CNT  = 6'h07
) (
    input  logic        dbg_clk,
    input  logic        dbg_rst,
    input  logic [5:0]  dbg_addr,
    input  logic [15:0] dbg_din,
    input  logic        dbg_wr,
    input  logic        dbg_rd,
    output logic [15:0] dbg_dout,
    output logic        dbg_rd_rdy,
    output logic        mem_burst,
    output logic        mem_burst_rd,
    output logic        mem_burst_wr,
    output logic        mem_burst_end,
    output logic        mem_bw,
    output logic        dbg_mem_en,
    output logic [15:0] dbg_mem_addr,
    output logic [15:0] dbg_mem_dout,
    output logic [1:0]  dbg_mem_wr,
    input  logic        dbg_mem_ack,
    input  logic [15:0] dbg_mem_din
);

    typedef enum logic [1:0] {IDLE, REQ, RDATA, WAIT} state_t;

    state_t      state;
    logic        ctl_rw;
    logic        ctl_bw;
    logic        first_acc;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic [15:0] mem_cnt;

    logic        busy;
    logic        wr_ctl, wr_addr, wr_data, wr_cnt;
    logic        rd_only, rd_data;
    logic        rd_burst;
    logic        reg_rd_rdy;
    logic        start;
    logic        access_done;
    logic [15:0] addr_step;
    logic [7:0]  rd_byte;

    assign busy     = (state != IDLE);
    assign wr_ctl   = dbg_wr && (dbg_addr == MEM_CTL);
    assign wr_addr  = dbg_wr && (dbg_addr == MEM_ADDR);
    assign wr_data  = dbg_wr && (dbg_addr == MEM_DATA);
    assign wr_cnt   = dbg_wr && (dbg_addr == MEM_CNT);
    // A simultaneous write strobe wins, so the read is dropped entirely.
    assign rd_only  = dbg_rd && !dbg_wr;
    assign rd_data  = rd_only && (dbg_addr == MEM_DATA);
    assign rd_burst = mem_burst && !ctl_rw;

    assign reg_rd_rdy = rd_only && ((dbg_addr == MEM_CTL) || (dbg_addr == MEM_ADDR) ||
                                    (dbg_addr == MEM_CNT) ||
                                    ((dbg_addr == MEM_DATA) && !rd_burst));

    assign start       = wr_ctl && dbg_din[0] && !busy;
    assign access_done = ((state == REQ) && dbg_mem_ack && ctl_rw) || (state == RDATA);
    assign addr_step   = ctl_bw ? 16'd1 : 16'd2;
    assign rd_byte     = mem_addr[0] ? dbg_mem_din[15:8] : dbg_mem_din[7:0];

    // Bus-side outputs decode registered state only, so async reset clears them at once.
    assign mem_bw       = ctl_bw;
    assign dbg_mem_en   = (state == REQ);
    assign dbg_mem_addr = ctl_bw ? mem_addr : {mem_addr[15:1], 1'b0};
    assign dbg_mem_dout = ctl_bw ? {mem_data[7:0], mem_data[7:0]} : mem_data;
    assign dbg_mem_wr   = ((state == REQ) && ctl_rw) ?
                          (ctl_bw ? (mem_addr[0] ? 2'b10 : 2'b01) : 2'b11) : 2'b00;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        dbg_dout = 16'h0000;
        case (dbg_addr)
            MEM_CTL:  dbg_dout = {12'h000, ctl_bw, 1'b0, ctl_rw, busy};
            MEM_ADDR: dbg_dout = mem_addr;
            MEM_DATA: dbg_dout = mem_data;
            MEM_CNT:  dbg_dout = mem_cnt;
            default:  dbg_dout = 16'h0000;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments in the
    // block deliberately override earlier ones (completion overrides the case below).
    always_ff @(posedge dbg_clk or posedge dbg_rst) begin
        if (dbg_rst) begin
            state         <= IDLE;
            ctl_rw        <= 1'b0;
            ctl_bw        <= 1'b0;
            first_acc     <= 1'b0;
            mem_addr      <= 16'h0000;
            mem_data      <= 16'h0000;
            mem_cnt       <= 16'h0000;
            mem_burst     <= 1'b0;
            mem_burst_rd  <= 1'b0;
            mem_burst_wr  <= 1'b0;
            mem_burst_end <= 1'b0;
            dbg_rd_rdy    <= 1'b0;
        end else begin
            mem_burst_rd  <= 1'b0;
            mem_burst_wr  <= 1'b0;
            mem_burst_end <= 1'b0;
            dbg_rd_rdy    <= (state == RDATA) || reg_rd_rdy;

            if (!busy) begin
                if (wr_addr) mem_addr <= dbg_din;
                if (wr_data) mem_data <= dbg_din;
                if (wr_cnt)  mem_cnt  <= dbg_din;
                if (wr_ctl) begin
                    ctl_rw <= dbg_din[1];
                    ctl_bw <= dbg_din[3];
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        first_acc <= 1'b1;
                        mem_burst <= (mem_cnt != 16'h0000);
                        // A write burst waits for its first data word from the front-end.
                        if (dbg_din[1] && (mem_cnt != 16'h0000)) begin
                            mem_burst_wr <= 1'b1;
                            state        <= WAIT;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dbg_mem_ack && !ctl_rw) state <= RDATA;
                end
                RDATA: begin
                    mem_data <= ctl_bw ? {8'h00, rd_byte} : dbg_mem_din;
                    if (first_acc && mem_burst) mem_burst_rd <= 1'b1;
                end
                WAIT: begin
                    if (ctl_rw ? wr_data : rd_data) begin
                        if (ctl_rw) mem_data <= dbg_din;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase

            if (access_done) begin
                first_acc <= 1'b0;
                if (!mem_burst) begin
                    state <= IDLE;
                end else begin
                    mem_addr <= mem_addr + addr_step;
                    if (mem_cnt != 16'h0000) begin
                        mem_cnt <= mem_cnt - 16'd1;
                        state   <= WAIT;
                    end else begin
                        mem_burst_end <= 1'b1;
                        mem_burst     <= 1'b0;
                        state         <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pu_msp430_dbg_mem_ctl.sv
// Bench for pu_msp430_dbg_mem_ctl: directed and random transactions against a byte-array
// memory model with a randomly delayed acknowledge responder.
module tb_pu_msp430_dbg_mem_ctl;

    localparam logic [5:0] A_CTL  = 6'h04;
    localparam logic [5:0] A_ADDR = 6'h05;
    localparam logic [5:0] A_DATA = 6'h06;
    localparam logic [5:0] A_CNT  = 6'h07;

    logic        dbg_clk = 1'b0;
    logic        dbg_rst = 1'b1;
    logic [5:0]  dbg_addr = 6'h00;
    logic [15:0] dbg_din = 16'h0000;
    logic        dbg_wr = 1'b0;
    logic        dbg_rd = 1'b0;
    logic [15:0] dbg_dout;
    logic        dbg_rd_rdy, mem_burst, mem_burst_rd, mem_burst_wr, mem_burst_end, mem_bw;
    logic        dbg_mem_en;
    logic [15:0] dbg_mem_addr, dbg_mem_dout;
    logic [1:0]  dbg_mem_wr;
    logic        dbg_mem_ack;
    logic [15:0] dbg_mem_din;

    pu_msp430_dbg_mem_ctl dut (
        .dbg_clk(dbg_clk), .dbg_rst(dbg_rst), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
        .dbg_wr(dbg_wr), .dbg_rd(dbg_rd), .dbg_dout(dbg_dout), .dbg_rd_rdy(dbg_rd_rdy),
        .mem_burst(mem_burst), .mem_burst_rd(mem_burst_rd), .mem_burst_wr(mem_burst_wr),
        .mem_burst_end(mem_burst_end), .mem_bw(mem_bw), .dbg_mem_en(dbg_mem_en),
        .dbg_mem_addr(dbg_mem_addr), .dbg_mem_dout(dbg_mem_dout), .dbg_mem_wr(dbg_mem_wr),
        .dbg_mem_ack(dbg_mem_ack), .dbg_mem_din(dbg_mem_din)
    );

    always #5 dbg_clk = ~dbg_clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem_b [0:65535];
    int          wait_left = 0;
    bit          resp_hold = 1'b0;
    logic [15:0] log_addr[$];
    logic [15:0] log_dout[$];
    logic [1:0]  log_wr[$];
    int          n_bwr = 0, n_brd = 0, n_bend = 0, n_rdy = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory responder: acks after a random delay, returns read data the cycle after ack.
    initial begin : responder
        logic [15:0] w;
        logic [15:0] rd_word;
        bit          rd_pending;
        rd_pending  = 1'b0;
        rd_word     = 16'h0000;
        dbg_mem_ack = 1'b0;
        dbg_mem_din = 16'h0000;
        forever begin
            @(negedge dbg_clk);
            dbg_mem_ack = 1'b0;
            if (rd_pending) begin
                dbg_mem_din = rd_word;
                rd_pending  = 1'b0;
            end else begin
                dbg_mem_din = 16'($urandom);
            end
            if (dbg_mem_en && !resp_hold && !dbg_rst) begin
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    dbg_mem_ack = 1'b1;
                    log_addr.push_back(dbg_mem_addr);
                    log_dout.push_back(dbg_mem_dout);
                    log_wr.push_back(dbg_mem_wr);
                    w = dbg_mem_addr & 16'hFFFE;
                    if (dbg_mem_wr == 2'b00) begin
                        rd_word    = {mem_b[w | 16'd1], mem_b[w]};
                        rd_pending = 1'b1;
                    end else begin
                        if (dbg_mem_wr[0]) mem_b[w] = dbg_mem_dout[7:0];
                        if (dbg_mem_wr[1]) mem_b[w | 16'd1] = dbg_mem_dout[15:8];
                    end
                    wait_left = $urandom_range(0, 3);
                end
            end
        end
    end

    initial begin : pulse_monitor
        forever begin
            @(negedge dbg_clk);
            if (mem_burst_wr)  n_bwr++;
            if (mem_burst_rd)  n_brd++;
            if (mem_burst_end) n_bend++;
            if (dbg_rd_rdy)    n_rdy++;
        end
    end

    task automatic tick();
        @(negedge dbg_clk);
        #1;
    endtask

    task automatic reg_wr(input logic [5:0] a, input logic [15:0] d);
        @(negedge dbg_clk);
        dbg_addr = a;
        dbg_din  = d;
        dbg_wr   = 1'b1;
        @(negedge dbg_clk);
        dbg_wr   = 1'b0;
    endtask

    task automatic peek(input logic [5:0] a, output logic [15:0] v);
        dbg_addr = a;
        #1;
        v = dbg_dout;
    endtask

    function automatic int get_count(input int which);
        case (which)
            0:       return log_addr.size();
            1:       return n_rdy;
            default: return n_bwr;
        endcase
    endfunction

    task automatic wait_until(input int which, input int n, input string tag);
        int k = 0;
        while (get_count(which) < n && k < 60) begin
            tick();
            k++;
        end
        if (get_count(which) < n) check({tag, " timeout"}, 16'(get_count(which)), 16'(n));
    endtask

    task automatic wait_idle(input string tag);
        logic [15:0] v;
        int k = 0;
        peek(A_CTL, v);
        while (v[0] && k < 80) begin
            tick();
            peek(A_CTL, v);
            k++;
        end
        check({tag, " idle"}, 16'(v[0]), 16'h0000);
    endtask

    // One complete transaction, with all expectations derived from the access rules.
    task automatic run_txn(input bit rw, input bit bw, input logic [15:0] addr,
                           input logic [15:0] cnt, input bit poke, input string tag);
        logic [15:0] wd[$];
        logic [15:0] a, got, exp, last_data, step;
        int          n;
        bit          burst;
        n         = int'(cnt) + 1;
        burst     = (cnt != 16'h0000);
        step      = bw ? 16'd1 : 16'd2;
        last_data = 16'h0000;
        for (int i = 0; i < n; i++) wd.push_back(16'($urandom));

        reg_wr(A_ADDR, addr);
        reg_wr(A_CNT, cnt);
        if (rw && !burst) reg_wr(A_DATA, wd[0]);
        log_addr.delete();
        log_dout.delete();
        log_wr.delete();
        n_bwr = 0; n_brd = 0; n_bend = 0; n_rdy = 0;
        reg_wr(A_CTL, {12'h000, bw, 1'b0, rw, 1'b1});
        #1;
        check({tag, " mem_bw"}, 16'(mem_bw), 16'(bw));

        for (int i = 0; i < n; i++) begin
            if (poke && i == 1) reg_wr(A_CNT, 16'h00FF);
            if (rw && burst) begin
                if (i == 0) wait_until(2, 1, {tag, " burst_wr"});
                reg_wr(A_DATA, wd[i]);
            end
            wait_until(0, i + 1, $sformatf("%s acc%0d", tag, i));
            if (!rw) begin
                wait_until(1, i + 1, $sformatf("%s rdy%0d", tag, i));
                a   = addr + 16'(i) * step;
                exp = bw ? {8'h00, mem_b[a]} : {mem_b[a | 16'd1], mem_b[a & 16'hFFFE]};
                peek(A_DATA, got);
                check($sformatf("%s rdata%0d", tag, i), got, exp);
                last_data = exp;
                if (i < n - 1) begin
                    @(negedge dbg_clk);
                    dbg_addr = A_DATA;
                    dbg_rd   = 1'b1;
                    @(negedge dbg_clk);
                    dbg_rd   = 1'b0;
                end
            end
        end
        wait_idle(tag);

        check({tag, " n_acc"}, 16'(log_addr.size()), 16'(n));
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            a = addr + 16'(i) * step;
            check($sformatf("%s addr%0d", tag, i), log_addr[i], bw ? a : (a & 16'hFFFE));
            check($sformatf("%s we%0d", tag, i), 16'(log_wr[i]),
                  rw ? (bw ? (a[0] ? 16'd2 : 16'd1) : 16'd3) : 16'd0);
            if (rw) check($sformatf("%s wdata%0d", tag, i), log_dout[i],
                          bw ? {wd[i][7:0], wd[i][7:0]} : wd[i]);
        end
        peek(A_ADDR, got);
        check({tag, " fin_addr"}, got, burst ? addr + 16'(n) * step : addr);
        peek(A_CNT, got);
        check({tag, " fin_cnt"}, got, 16'h0000);
        peek(A_DATA, got);
        check({tag, " fin_data"}, got, rw ? wd[n - 1] : last_data);
        peek(A_CTL, got);
        check({tag, " fin_ctl"}, got, {12'h000, bw, 1'b0, rw, 1'b0});
        check({tag, " n_burst_wr"}, 16'(n_bwr), 16'(rw && burst));
        check({tag, " n_burst_rd"}, 16'(n_brd), 16'(!rw && burst));
        check({tag, " n_burst_end"}, 16'(n_bend), 16'(burst));
        check({tag, " n_rd_rdy"}, 16'(n_rdy), rw ? 16'd0 : 16'(n));
        check({tag, " burst_flag"}, 16'(mem_burst), 16'h0000);
    endtask

    initial begin : main
        logic [15:0] v;
        int k;
        for (int i = 0; i < 65536; i++) mem_b[i] = 8'($urandom);

        // Reset state
        repeat (2) @(negedge dbg_clk);
        peek(A_CTL, v);  check("rst ctl", v, 16'h0000);
        peek(A_ADDR, v); check("rst addr", v, 16'h0000);
        peek(A_DATA, v); check("rst data", v, 16'h0000);
        peek(A_CNT, v);  check("rst cnt", v, 16'h0000);
        check("rst outs", {9'h000, dbg_mem_en, dbg_mem_wr, mem_burst, mem_burst_rd,
                           mem_burst_wr, dbg_rd_rdy}, 16'h0000);
        @(negedge dbg_clk);
        dbg_rst = 1'b0;

        // Single word read with a two-cycle ack delay
        mem_b[16'h0200] = 8'hEF;
        mem_b[16'h0201] = 8'hBE;
        wait_left = 2;
        run_txn(1'b0, 1'b0, 16'h0200, 16'h0000, 1'b0, "word_rd");
        peek(A_DATA, v);
        check("word_rd beef", v, 16'hBEEF);

        run_txn(1'b1, 1'b1, 16'h0201, 16'h0000, 1'b0, "byte_wr");
        check("byte_wr mem", 16'(mem_b[16'h0201]), 16'(log_dout.size() > 0 ? log_dout[0][7:0] : 8'hxx));
        run_txn(1'b1, 1'b0, 16'h1000, 16'h0002, 1'b0, "word_wr_burst");
        run_txn(1'b0, 1'b1, 16'h00FF, 16'h0001, 1'b0, "byte_rd_burst");
        run_txn(1'b0, 1'b0, 16'hFFFE, 16'h0001, 1'b1, "wrap_rd");
        run_txn(1'b1, 1'b0, 16'hFFFE, 16'h0001, 1'b1, "wrap_wr");
        run_txn(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, "wrap_byte");

        // Write wins over a simultaneous read; a plain register read gives one rd_rdy
        n_rdy = 0;
        @(negedge dbg_clk);
        dbg_addr = A_ADDR; dbg_din = 16'h1234; dbg_wr = 1'b1; dbg_rd = 1'b1;
        @(negedge dbg_clk);
        dbg_wr = 1'b0; dbg_rd = 1'b0;
        tick();
        check("wr_prio rdy", 16'(n_rdy), 16'h0000);
        peek(A_ADDR, v);
        check("wr_prio addr", v, 16'h1234);
        @(negedge dbg_clk);
        dbg_addr = A_CNT; dbg_rd = 1'b1;
        @(negedge dbg_clk);
        dbg_rd = 1'b0;
        #1;
        check("reg_rd rdy", 16'(n_rdy), 16'h0001);

        // Reset while a request is waiting for its ack
        reg_wr(A_ADDR, 16'h0300);
        reg_wr(A_CNT, 16'h0000);
        resp_hold = 1'b1;
        reg_wr(A_CTL, 16'h0001);
        k = 0;
        while (!dbg_mem_en && k < 10) begin
            tick();
            k++;
        end
        check("rst_mid en_before", 16'(dbg_mem_en), 16'h0001);
        #2 dbg_rst = 1'b1;
        #1;
        check("rst_mid en_after", 16'(dbg_mem_en), 16'h0000);
        peek(A_CTL, v);  check("rst_mid ctl", v, 16'h0000);
        peek(A_ADDR, v); check("rst_mid addr", v, 16'h0000);
        peek(A_DATA, v); check("rst_mid data", v, 16'h0000);
        check("rst_mid burst", 16'(mem_burst), 16'h0000);
        @(negedge dbg_clk);
        dbg_rst   = 1'b0;
        resp_hold = 1'b0;
        run_txn(1'b0, 1'b0, 16'h0300, 16'h0000, 1'b0, "after_rst");

        // Random transactions
        for (int t = 0; t < 16; t++) begin
            bit          rw, bw;
            logic [15:0] ad, cn;
            rw = 1'($urandom_range(0, 1));
            bw = 1'($urandom_range(0, 1));
            ad = 16'($urandom);
            cn = 16'($urandom_range(0, 3));
            run_txn(rw, bw, ad, cn, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
